// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux
// Time-multiplexing front end for a 4-digit common-anode 7-segment display.
// A 4-digit packed BCD value is shown one digit per slot on a 4-bit bus that
// drives a BCD-to-7-segment decoder, with matching active-low anode enables.
// New values arrive over a valid/ready port, wait in a one-entry pending
// buffer, and are copied to the displayed value only at a frame boundary so a
// frame is never drawn with a mix of old and new digits.
//
// Parameters
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   GUARD     cycles at the start of each slot with all anodes off (< SCAN_DIV)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   digits_in   packed BCD value, [3:0] = digit 0 (LSD), [15:12] = digit 3
//   load_valid  digits_in is valid this cycle
//   load_ready  pending buffer is empty, a load is accepted this cycle
//   blank_lz    1 = blank leading zero digits (digit 0 is always shown)
//   bcd         digit of the current slot (driven in guard/blanked cycles too)
//   an_n        active-low anode enables, bit k selects digit k
//   digit_idx   current slot index
module bcd_scan_mux #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an_n,
  output logic [1:0]  digit_idx
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   pend;
  logic          pend_full;

  logic slot_end;
  logic frame_end;
  logic accept;
  logic blanked;

  // Slot k (k >= 1) is a leading zero when digits k..3 of v are all zero.
  // Non-BCD nibbles are non-zero here, so they are never blanked.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
    logic r;
    case (k)
      2'd1:    r = (v[15:4]  == 12'h000);
      2'd2:    r = (v[15:8]  == 8'h00);
      2'd3:    r = (v[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);
  assign accept    = load_valid && !pend_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= 2'd0;
      shadow    <= 16'h0000;
      pend      <= 16'h0000;
      pend_full <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // A full buffer cannot accept, so transfer and accept never collide;
      // a load taken in the boundary cycle waits in pend for the next frame.
      if (frame_end && pend_full) begin
        shadow    <= pend;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend      <= digits_in;
        pend_full <= 1'b1;
      end
    end
  end

  // Outputs depend only on registered state, except blank_lz -> an_n.
  always_comb begin
    load_ready = !pend_full;
    digit_idx  = idx;
    bcd        = shadow[{idx, 2'b00} +: 4];
    blanked    = blank_lz && lz_blank(shadow, idx);
    if (((GUARD > 0) && (cnt < CW'(GUARD))) || blanked)
      an_n = 4'b1111;
    else
      an_n = ~(4'b0001 << idx);
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Self-checking bench for bcd_scan_mux with SCAN_DIV = 8, GUARD = 2.
// A frame-position reference model (position 0..31 within a 32-cycle frame,
// displayed value, pending queue) predicts every output on every cycle; the
// directed sequences and the blanking table add explicit expected constants.
module tb_bcd_scan_mux;

  localparam int SD  = 8;
  localparam int GD  = 2;
  localparam int FRM = 4 * SD;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load_valid;
  logic        load_ready;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_pend_q[$];

  bcd_scan_mux #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an_n       (an_n),
    .digit_idx  (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        blz;
    logic [15:0] an_exp;   // nibble k = expected an_n in lit part of slot k
    logic [15:0] bcd_exp;  // nibble k = expected bcd in slot k
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_bcd();
    int slot = m_pos / SD;
    return 4'((m_shadow >> (4 * slot)) & 16'hF);
  endfunction

  function automatic logic [3:0] m_an();
    int slot = m_pos / SD;
    int sub  = m_pos % SD;
    logic blank = blank_lz && (slot > 0) && ((m_shadow >> (4 * slot)) == 16'h0);
    if (sub < GD || blank) return 4'hF;
    return 4'hF ^ 4'(1 << slot);
  endfunction

  task automatic m_reset();
    m_pos    = 0;
    m_shadow = 16'h0000;
    m_pend_q.delete();
  endtask

  task automatic m_edge();
    if (!rst_n) begin
      m_reset();
    end else begin
      if (m_pos == FRM - 1 && m_pend_q.size() != 0)
        m_shadow = m_pend_q.pop_front();
      else if (load_valid && m_pend_q.size() == 0)
        m_pend_q.push_back(digits_in);
      m_pos = (m_pos + 1) % FRM;
    end
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic tick();
    #1;
    chk("model.bcd",   {12'h0, bcd},       {12'h0, m_bcd()});
    chk("model.an_n",  {12'h0, an_n},      {12'h0, m_an()});
    chk("model.idx",   {14'h0, digit_idx}, 16'(m_pos / SD));
    chk("model.ready", {15'h0, load_ready}, {15'h0, (m_pend_q.size() == 0)});
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (m_pos != p && n < 2 * FRM) begin
      tick();
      n++;
    end
    n_cmp++;
    if (m_pos != p) begin
      n_bad++;
      $display("FAIL wait_pos: got %0d, expected %0d", m_pos, p);
    end
  endtask

  task automatic load(input logic [15:0] v);
    digits_in  = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0045, 1'b1, 16'hFFDE, 16'h0045};
    vecs[1] = '{16'h0000, 1'b1, 16'hFFFE, 16'h0000};
    vecs[2] = '{16'h0045, 1'b0, 16'h7BDE, 16'h0045};
    vecs[3] = '{16'h0A00, 1'b1, 16'hFBDE, 16'h0A00};
    vecs[4] = '{16'h1000, 1'b1, 16'h7BDE, 16'h1000};
    vecs[5] = '{16'h0100, 1'b1, 16'hFBDE, 16'h0100};

    // ---- reset held 3 cycles with load_valid high
    rst_n      = 1'b0;
    load_valid = 1'b1;
    digits_in  = 16'hFFFF;
    blank_lz   = 1'b0;
    @(posedge clk);
    m_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst.an_n",  {12'h0, an_n},       16'h000F);
      chk("rst.bcd",   {12'h0, bcd},        16'h0000);
      chk("rst.idx",   {14'h0, digit_idx},  16'h0000);
      chk("rst.ready", {15'h0, load_ready}, 16'h0001);
      if (i < 2) tick();
    end
    rst_n      = 1'b1;
    load_valid = 1'b0;
    for (int i = 0; i < SD; i++) begin
      chk("slot0.an_n", {12'h0, an_n}, (i < GD) ? 16'h000F : 16'h000E);
      chk("slot0.bcd",  {12'h0, bcd},  16'h0000);
      tick();
    end

    // ---- load 1234 during slot 1
    wait_pos(SD + 3);
    load(16'h1234);
    chk("load.ready_low", {15'h0, load_ready}, 16'h0000);
    wait_pos(0);
    chk("load.ready_high", {15'h0, load_ready}, 16'h0001);
    wait_pos(2);
    chk("load.s0.bcd", {12'h0, bcd}, 16'h0004);
    chk("load.s0.an",  {12'h0, an_n}, 16'h000E);
    wait_pos(3 * SD + 2);
    chk("load.s3.bcd", {12'h0, bcd}, 16'h0001);
    chk("load.s3.an",  {12'h0, an_n}, 16'h0007);

    // ---- back-pressure: 5678 held while 1111 is pending
    wait_pos(SD);
    load(16'h1111);
    digits_in  = 16'h5678;
    load_valid = 1'b1;
    wait_pos(0);
    tick();
    load_valid = 1'b0;
    chk("bp.ready_low", {15'h0, load_ready}, 16'h0000);
    wait_pos(2);
    chk("bp.first", {12'h0, bcd}, 16'h0001);
    wait_pos(0);
    wait_pos(2);
    chk("bp.s0", {12'h0, bcd}, 16'h0008);
    wait_pos(3 * SD + 2);
    chk("bp.s3", {12'h0, bcd}, 16'h0005);

    // ---- acceptance in the boundary cycle
    wait_pos(FRM - 1);
    load(16'h9999);
    chk("bnd.ready_low", {15'h0, load_ready}, 16'h0000);
    wait_pos(2);
    chk("bnd.old", {12'h0, bcd}, 16'h0008);
    wait_pos(0);
    wait_pos(2);
    chk("bnd.new", {12'h0, bcd}, 16'h0009);

    // ---- blanking table
    foreach (vecs[v]) begin
      logic [15:0] ae;
      logic [15:0] be;
      ae = vecs[v].an_exp;
      be = vecs[v].bcd_exp;
      blank_lz = vecs[v].blz;
      wait_pos(4);
      load(vecs[v].val);
      wait_pos(0);
      for (int k = 0; k < 4; k++) begin
        wait_pos(k * SD);
        chk("tbl.guard_an", {12'h0, an_n}, 16'h000F);
        wait_pos(k * SD + 3);
        chk("tbl.an",  {12'h0, an_n}, {12'h0, ae[4*k +: 4]});
        chk("tbl.bcd", {12'h0, bcd},  {12'h0, be[4*k +: 4]});
      end
    end
    blank_lz = 1'b0;

    // ---- reset mid-frame with 4321 pending
    wait_pos(4);
    load(16'h4321);
    wait_pos(2 * SD + 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.ready", {15'h0, load_ready}, 16'h0001);
    chk("mrst.idx",   {14'h0, digit_idx},  16'h0000);
    for (int i = 0; i < 2 * FRM; i++) begin
      chk("mrst.bcd", {12'h0, bcd}, 16'h0000);
      tick();
    end

    // ---- randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(3) == 0);
      digits_in  = 16'($urandom);
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(400) != 0);
      tick();
    end
    rst_n      = 1'b1;
    load_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_mux.md
# bcd_scan_mux

Time-multiplexing front end for the 4-digit common-anode 7-segment display. It holds a 4-digit packed BCD value and presents one digit at a time on a 4-bit BCD bus that drives the BCD-to-7-segment decoder directly, with matching active-low anode enables. It also provides:
- a valid/ready load port whose updates take effect only at frame boundaries, so a new value never appears part-way through a scan;
- anti-ghosting guard intervals between digit slots;
- optional leading-zero blanking.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range ≥ 2
- GUARD, 2, cycles at the start of each slot with all anodes off; legal range 0 ≤ GUARD < SCAN_DIV

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  synchronous, active-low reset
- digits_in  input  16  packed BCD value; [3:0] is digit 0 (least significant), [15:12] is digit 3
- load_valid  input  1  digits_in is valid this cycle
- load_ready  output  1  block can accept a load this cycle
- blank_lz  input  1  1 = enable leading-zero blanking
- bcd  output  4  BCD of the current slot's digit; feeds the decoder's bcd input
- an_n  output  4  active-low anode enables; bit k selects digit k
- digit_idx  output  2  current slot index

## Operation
- State registers:
  - cnt: slot counter, width $clog2(SCAN_DIV)
  - idx: 2-bit slot index
  - shadow[15:0]: displayed value
  - pend[15:0]: pending value
  - pend_full: pending-buffer flag
- Prescaler:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt == SCAN_DIV-1: cnt wraps to 0 and idx increments modulo 4 (sequence 0,1,2,3,0).
- Frame boundary: the cycle where cnt == SCAN_DIV-1 and idx == 3.
- Load handshake:
  - load_ready = !pend_full (combinational from state).
  - A load is accepted when load_valid && load_ready: pend ← digits_in, pend_full ← 1.
  - If load_valid is high while load_ready is low, the data is ignored. The source holds it until accepted.
- Transfer to display:
  - At a frame boundary with pend_full == 1 (pre-edge value): shadow ← pend, pend_full ← 0.
  - If a load is accepted in the boundary cycle itself (only possible when pend_full == 0), it goes into pend only. shadow is unchanged, and the value displays from the following frame.
- Output decode (combinational from registered state plus blank_lz):
  - bcd = shadow[4*idx+3 : 4*idx] in every cycle, including guard and blanked cycles.
  - digit_idx = idx.
  - an_n = 4'b1111 when cnt < GUARD, or when the current slot is blanked.
  - Otherwise an_n has only bit idx low (idx 0 → 4'b1110, idx 3 → 4'b0111).
- Leading-zero blanking: when blank_lz == 1, slot k (k = 1..3) is blanked if shadow digits k through 3 are all 4'h0. Digit 0 is never blanked.
- Non-BCD nibbles (4'hA–4'hF) are passed through on bcd unmodified and are never treated as zero for blanking.
- Reset (rst_n low at a rising edge, including mid-frame):
  - cnt = 0, idx = 0, shadow = 0, pend = 0, pend_full = 0.
  - Any pending load is discarded.

## Timing
- Reset values of outputs: load_ready = 1, bcd = 4'h0, digit_idx = 0. an_n = 4'b1111 if GUARD > 0, otherwise 4'b1110.
- Slot length is SCAN_DIV cycles; frame length is 4·SCAN_DIV cycles.
- Digit k is lit during slot cycles GUARD..SCAN_DIV-1 only.
- Load-to-display latency:
  - Accepted in a non-boundary cycle: shown from the first cycle of the next frame (idx 0, cnt 0).
  - Accepted in the boundary cycle: shown one frame later.
- load_ready:
  - Falls in the cycle after acceptance.
  - Rises in the cycle after the transfer boundary.
  - Maximum throughput is one load per frame.
- No combinational path from load_valid or digits_in to any output. blank_lz → an_n is combinational.

## Test plan
Benches use SCAN_DIV = 8, GUARD = 2.
- Reset: hold rst_n low 3 cycles with load_valid = 1 → during reset and in the first cycle after release: an_n = 4'b1111, bcd = 0, digit_idx = 0, load_ready = 1. After release, slot 0 cycles 0–1 give an_n = 4'b1111 and cycles 2–7 give an_n = 4'b1110.
- Load 16'h1234 during idx 1:
  - Next cycle: load_ready = 0.
  - Next frame: slot 0 gives bcd = 4 with an_n = 4'b1110; slot 3 gives bcd = 1 with an_n = 4'b0111.
  - load_ready = 1 from the cycle after the boundary.
- Back-pressure: after 16'h1234 is pending, hold load_valid with 16'h5678 → not accepted while load_ready = 0. It is accepted the cycle load_ready rises, and displays one frame after 1234.
- Boundary acceptance: pend empty, load 16'h9999 exactly in the boundary cycle → the next frame still shows the old shadow; 9999 appears in the frame after.
- Leading-zero blanking:
  - shadow = 16'h0045, blank_lz = 1 → slots 2 and 3 have an_n = 4'b1111 for the whole slot.
  - shadow = 16'h0000 → only slot 0 lit, bcd = 0.
  - blank_lz = 0 → all four slots lit.
- Reset mid-frame: at idx 2 with a pending load of 16'h4321, assert rst_n → shadow = 0, load_ready = 1 after reset. 4321 never appears on bcd.
